// File: rtl/vscpu_mem_dump.sv
// vscpu_mem_dump: reads a window of words from the VSCPU block RAM and streams them out as (address, data).
// Latency: first out_valid 3 cycles after an accepted start, then 1 word per 3 cycles with out_ready high.
// Backpressure: out_valid/out_addr/out_data hold until out_ready; no further RAM read is issued meanwhile.
//
// Ports:
//   clk, rst            clock and asynchronous active-high reset
//   start               1-cycle request, only honoured while idle
//   base_addr, count    window start and length, latched on an accepted start (count 0 is legal)
//   busy, done          busy during the dump; done pulses once when the window is finished
//   mem_we/addr/din     single-port RAM request side (write enable and write data held at 0)
//   mem_dout            RAM registered read data, valid the cycle after mem_addr
//   out_valid/ready     stream handshake
//   out_addr, out_data  address and data of the current stream word
//   checksum            only with VSCPU_DUMP_CHECKSUM_EN: wrapping 32-bit sum of the accepted words
//
// Build option: define VSCPU_DUMP_CHECKSUM_EN to add the checksum output.

module vscpu_mem_dump #(
  parameter int SIZE  = 14,
  parameter int DEPTH = 16384
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [SIZE-1:0] base_addr,
  input  logic [SIZE:0]   count,
  output logic            busy,
  output logic            done,
  output logic            mem_we,
  output logic [SIZE-1:0] mem_addr,
  output logic [31:0]     mem_din,
  input  logic [31:0]     mem_dout,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [SIZE-1:0] out_addr,
  output logic [31:0]     out_data
`ifdef VSCPU_DUMP_CHECKSUM_EN
  ,
  output logic [31:0]     checksum
`endif
);

  // Highest RAM address; the pointer steps from here back to 0.
  localparam logic [SIZE-1:0] LAST_ADDR = SIZE'(DEPTH - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ISSUE   = 3'd1,
    S_CAPTURE = 3'd2,
    S_OUT     = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [SIZE-1:0] ptr_q, ptr_d;
  logic [SIZE:0]   remaining_q, remaining_d;
  logic            out_valid_q, out_valid_d;
  logic [SIZE-1:0] out_addr_q, out_addr_d;
  logic [31:0]     out_data_q, out_data_d;
`ifdef VSCPU_DUMP_CHECKSUM_EN
  logic [31:0]     checksum_q, checksum_d;
`endif

  logic            handshake;
  assign handshake = out_valid_q && out_ready;

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      remaining_q <= '0;
      out_valid_q <= 1'b0;
      out_addr_q  <= '0;
      out_data_q  <= '0;
`ifdef VSCPU_DUMP_CHECKSUM_EN
      checksum_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      remaining_q <= remaining_d;
      out_valid_q <= out_valid_d;
      out_addr_q  <= out_addr_d;
      out_data_q  <= out_data_d;
`ifdef VSCPU_DUMP_CHECKSUM_EN
      checksum_q  <= checksum_d;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = (count == '0) ? S_DONE : S_ISSUE;
        end
      end
      S_ISSUE:   state_d = S_CAPTURE;
      S_CAPTURE: state_d = S_OUT;
      S_OUT: begin
        if (handshake) begin
          // remaining_q still counts the word being accepted now.
          state_d = (remaining_q == (SIZE+1)'(1)) ? S_DONE : S_ISSUE;
        end
      end
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath next values
  // ---------------------------------------------------------------------------
  always_comb begin
    ptr_d       = ptr_q;
    remaining_d = remaining_q;
    out_valid_d = out_valid_q;
    out_addr_d  = out_addr_q;
    out_data_d  = out_data_q;
`ifdef VSCPU_DUMP_CHECKSUM_EN
    checksum_d  = checksum_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          ptr_d       = base_addr;
          remaining_d = count;
`ifdef VSCPU_DUMP_CHECKSUM_EN
          checksum_d  = '0;
`endif
        end
      end
      S_CAPTURE: begin
        // mem_dout answers the address issued in the previous cycle.
        out_data_d  = mem_dout;
        out_addr_d  = ptr_q;
        out_valid_d = 1'b1;
      end
      S_OUT: begin
        if (handshake) begin
          out_valid_d = 1'b0;
          ptr_d       = (ptr_q == LAST_ADDR) ? '0 : ptr_q + 1'b1;
          remaining_d = remaining_q - 1'b1;
`ifdef VSCPU_DUMP_CHECKSUM_EN
          checksum_d  = checksum_q + out_data_q;
`endif
        end
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    busy      = 1'b0;
    done      = 1'b0;
    mem_we    = 1'b0;
    mem_din   = '0;
    mem_addr  = '0;
    case (state_q)
      S_ISSUE: begin
        busy     = 1'b1;
        mem_addr = ptr_q;
      end
      S_CAPTURE: busy = 1'b1;
      S_OUT:     busy = 1'b1;
      S_DONE:    done = 1'b1;
      default: ;
    endcase
  end

  assign out_valid = out_valid_q;
  assign out_addr  = out_addr_q;
  assign out_data  = out_data_q;
`ifdef VSCPU_DUMP_CHECKSUM_EN
  assign checksum  = checksum_q;
`endif

endmodule

// File: tb/tb_vscpu_mem_dump.sv
// Testbench for vscpu_mem_dump: RAM model, stream/timing reference model, directed scenarios.
module tb_vscpu_mem_dump;
  localparam int SIZE  = 14;
  localparam int DEPTH = 1 << SIZE;

  typedef struct packed {
    logic [SIZE-1:0] a;
    logic [31:0]     d;
  } word_t;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            start = 1'b0;
  logic [SIZE-1:0] base_addr = '0;
  logic [SIZE:0]   count = '0;
  logic            busy, done, mem_we;
  logic [SIZE-1:0] mem_addr;
  logic [31:0]     mem_din;
  logic [31:0]     mem_dout;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [SIZE-1:0] out_addr;
  logic [31:0]     out_data;
`ifdef VSCPU_DUMP_CHECKSUM_EN
  logic [31:0]     checksum;
`endif

  vscpu_mem_dump #(.SIZE(SIZE), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .count(count),
    .busy(busy), .done(done), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_dout(mem_dout), .out_valid(out_valid), .out_ready(out_ready),
    .out_addr(out_addr), .out_data(out_data)
`ifdef VSCPU_DUMP_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  always #5 clk = ~clk;

  // Block RAM with one-cycle registered read; written only by the stimulus.
  logic [31:0] ram [0:DEPTH-1];
  always @(posedge clk) mem_dout <= ram[mem_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: a dump is a queue of (addr, data) words; each word
  // appears 3 cycles after the start or after the previous transfer, and done
  // follows the last transfer (or a zero-length start) by one cycle.
  bit          m_act = 0;
  bit          m_done = 0;
  int          m_wait = 0;
  word_t       m_q[$];
  logic [31:0] m_csum = '0;

  word_t log_q[$];
  int    log_cyc[$];
  int    done_cnt = 0;
  int    done_cyc = 0;
  int    start_cyc = 0;

  always @(negedge clk) begin : compare
    bit    exp_valid;
    bit    nd;
    word_t w;
    check("mem_we", mem_we, 0);
    check("mem_din", mem_din, 0);
    if (rst) begin
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_mem_addr", mem_addr, 0);
      check("rst_out_addr", out_addr, 0);
      check("rst_out_data", out_data, 0);
`ifdef VSCPU_DUMP_CHECKSUM_EN
      check("rst_checksum", checksum, 0);
`endif
      m_act = 0; m_done = 0; m_wait = 0; m_csum = '0;
      m_q.delete();
    end else begin
      exp_valid = m_act && (m_wait == 0);
      check("busy", busy, m_act);
      check("done", done, m_done);
      check("out_valid", out_valid, exp_valid);
      if (exp_valid) begin
        check("out_addr", out_addr, m_q[0].a);
        check("out_data", out_data, m_q[0].d);
      end
`ifdef VSCPU_DUMP_CHECKSUM_EN
      check("checksum", checksum, m_csum);
`endif
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      nd = 0;
      if (m_act) begin
        if (exp_valid && out_ready) begin
          log_q.push_back(m_q[0]);
          log_cyc.push_back(cyc);
          m_csum = m_csum + m_q[0].d;
          void'(m_q.pop_front());
          if (m_q.size() == 0) begin
            m_act = 0;
            nd = 1;
          end else begin
            m_wait = 2;
          end
        end else if (m_wait > 0) begin
          m_wait--;
        end
      end else if (!m_done && start) begin
        start_cyc = cyc;
        m_csum = '0;
        for (int i = 0; i < int'(count); i++) begin
          w.a = SIZE'(int'(base_addr) + i);
          w.d = ram[w.a];
          m_q.push_back(w);
        end
        if (count == '0) nd = 1;
        else begin
          m_act = 1;
          m_wait = 2;
        end
      end
      m_done = nd;
    end
  end

  task automatic go(input int b, input int c);
    @(posedge clk); #1;
    base_addr = SIZE'(b);
    count = (SIZE+1)'(c);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int d0;
    int i;
    d0 = done_cnt;
    for (i = 0; i < budget && done_cnt == d0; i++) @(negedge clk);
    check("done_timeout", done_cnt != d0, 1);
  endtask

  initial begin : stim
    int n0;
    int d0;
    for (int i = 0; i < DEPTH; i++) ram[i] = 32'(i) ^ 32'hA5A5_0000;
    ram[100] = 32'd5;
    ram[101] = 32'd8;
    ram[102] = 32'd16;
    ram[103] = 32'hFFFF_FFFF;
    ram[111] = 32'd1;
    ram[16383] = 32'd7;
    ram[0] = 32'h8E00_C003;

    // 1. Reset
    #15 rst = 1'b0;
    #1;
    check("post_rst_valid", out_valid, 0);
    check("post_rst_busy", busy, 0);
    check("post_rst_addr", mem_addr, 0);
    check("post_rst_data", out_data, 0);

    // 2. Four-word dump
    out_ready = 1'b1;
    n0 = log_q.size();
    go(100, 4);
    wait_done(60);
    check("t2_words", log_q.size() - n0, 4);
    check("t2_w0", log_q[n0], {14'd100, 32'd5});
    check("t2_w1", log_q[n0+1], {14'd101, 32'd8});
    check("t2_w2", log_q[n0+2], {14'd102, 32'd16});
    check("t2_w3", log_q[n0+3], {14'd103, 32'hFFFF_FFFF});
    check("t2_first_lat", log_cyc[n0] - start_cyc, 3);
    check("t2_last_lat", log_cyc[n0+3] - start_cyc, 12);
    check("t2_done_lat", done_cyc - start_cyc, 13);
`ifdef VSCPU_DUMP_CHECKSUM_EN
    #1 check("t2_checksum", checksum, 32'h0000_001C);
`endif

    // 3. Backpressure
    out_ready = 1'b0;
    n0 = log_q.size();
    d0 = done_cnt;
    go(111, 1);
    repeat (5) @(posedge clk);
    #1;
    check("t3_held_valid", out_valid, 1);
    check("t3_held_data", out_data, 1);
    out_ready = 1'b1;
    wait_done(20);
    check("t3_words", log_q.size() - n0, 1);
    check("t3_done_pulses", done_cnt - d0, 1);

    // 4. Address wrap
    n0 = log_q.size();
    go(16383, 2);
    wait_done(30);
    check("t4_words", log_q.size() - n0, 2);
    check("t4_w0", log_q[n0], {14'd16383, 32'd7});
    check("t4_w1", log_q[n0+1], {14'd0, 32'h8E00_C003});

    // 5a. Zero-length window
    n0 = log_q.size();
    go(50, 0);
    wait_done(5);
    check("t5_zero_lat", done_cyc - start_cyc, 1);
    check("t5_zero_words", log_q.size() - n0, 0);

    // 5b. start while busy is ignored
    n0 = log_q.size();
    d0 = done_cnt;
    go(200, 2);
    @(posedge clk); #1;
    base_addr = SIZE'(300);
    count = (SIZE+1)'(1);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(30);
    repeat (6) @(posedge clk);
    #1;
    check("t5_busy_words", log_q.size() - n0, 2);
    check("t5_busy_addr0", log_q[n0].a, 200);
    check("t5_busy_addr1", log_q[n0+1].a, 201);
    check("t5_busy_dones", done_cnt - d0, 1);
    check("t5_busy_idle", busy, 0);

    // 5c. start coinciding with the done pulse is ignored
    n0 = log_q.size();
    go(210, 1);
    for (int i = 0; i < 20; i++) begin
      if (done) break;
      @(posedge clk); #1;
    end
    check("t5_done_seen", done, 1);
    base_addr = SIZE'(400);
    count = (SIZE+1)'(2);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check("t5_done_start_words", log_q.size() - n0, 1);
    check("t5_done_start_idle", busy, 0);

    // 6. Reset mid-dump aborts; a fresh dump afterwards completes
    n0 = log_q.size();
    d0 = done_cnt;
    go(120, 3);
    for (int i = 0; i < 20; i++) begin
      if (log_q.size() != n0) break;
      @(posedge clk);
    end
    check("t6_first_word", log_q.size() - n0, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("t6_abort_busy", busy, 0);
    check("t6_abort_valid", out_valid, 0);
    check("t6_abort_data", out_data, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("t6_no_done", done_cnt - d0, 0);
    n0 = log_q.size();
    go(130, 2);
    wait_done(30);
    check("t6_fresh_words", log_q.size() - n0, 2);
    check("t6_fresh_w1", log_q[n0+1], {14'd131, 32'd131 ^ 32'hA5A5_0000});

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule
